mod_seq_ctrl: RTL and testbench
===============================

Name: mod_seq_ctrl

Overview:
Programmable modulus-sequence scheduler. It steps a single shared counter through a table of up to NPH phases. Each phase counts 0..mod and repeats rep times. It generalises the fixed alternating mod-4/mod-5 counter into a configurable controller with start/stop sequencing, one-shot or looped operation, and status pulses for downstream timing logic.

Parameters:
CW, 4, count width; also the width of the per-phase terminal value
NPH, 4, number of phase table entries
PW, 2, phase index width (clog2(NPH))
RW, 4, per-phase repeat-count width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
cfg_we  input  1  table write strobe
cfg_addr  input  PW  table entry to write
cfg_mod  input  CW  terminal count for the entry; the phase counts 0..cfg_mod
cfg_rep  input  RW  passes for the entry; 0 means the phase is skipped
start  input  1  begin a sequence; honoured in IDLE only
start_last  input  PW  last phase index used; sampled with start
start_loop  input  1  1 = wrap to phase 0 after the last phase; sampled with start
stop  input  1  abort the sequence
count  output  CW  current count value
phase  output  PW  current phase index
tick  output  1  count at terminal value this cycle
phase_done  output  1  final pass of the current phase ends this cycle
busy  output  1  sequence in progress
done  output  1  one-cycle pulse when a non-loop sequence completes
cfg_err  output  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; count=0, phase=0, pass counter=0.
  - All table entries mod=0, rep=0; latched last=0, loop=0.
  - tick, phase_done, busy, done, cfg_err all 0.
- Table write:
  - cfg_we in IDLE or END writes {cfg_mod, cfg_rep} at cfg_addr on that edge.
  - cfg_we while busy is dropped and cfg_err=1 for the next cycle.
- States:
  - IDLE: busy=0, count=0, phase=0. On start, latch last/loop, set phase<=0 and pass<=0, go to SEEK.
  - SEEK: one cycle per step, busy=1, count held 0, tick=0. The state is based on rep[phase].
    - rep[phase]!=0: go to RUN, pass<=0.
    - rep[phase]=0 and phase<last: phase<=phase+1, stay in SEEK.
    - rep[phase]=0 and phase==last: if loop and any entry 0..last has rep!=0, phase<=0 and stay in SEEK; otherwise go to END.
  - RUN: busy=1. Each cycle count<=count+1 until count==mod[phase].
    - tick is a combinational decode: (state==RUN && count==mod[phase]).
    - On a tick cycle: count<=0, pass<=pass+1.
    - phase_done = tick && pass==rep[phase]-1. On a phase_done cycle: pass<=0.
      - phase<last: phase<=phase+1, go to SEEK.
      - phase==last and loop: phase<=0, go to SEEK.
      - Otherwise: go to END.
    - mod[phase]=0 means each pass lasts 1 cycle and tick=1 every RUN cycle.
  - END: single cycle, busy=0, done=1, count=0, phase=0; then IDLE. A start in END is ignored.
- Phase transitions: every phase change costs exactly one SEEK bubble cycle (count=0, tick=0). Each skipped entry costs one more cycle.
- stop: highest priority after reset. In SEEK or RUN, the next edge forces IDLE with count=0, phase=0, pass=0 and no done. stop in IDLE or END has no effect.
- start while busy is ignored. start and stop together in IDLE: stop wins, no start.
- Arithmetic: count is CW-bit and pass is RW-bit, both unsigned. Neither can overflow, because count is cleared at mod and pass is cleared at rep-1.
- Table and start inputs: table contents and last/loop are frozen while busy, because writes are rejected and start is sampled only in IDLE.

Test Plan:
- Reset mid-RUN (rst low at count=2) -> all outputs 0 immediately; table reads back mod=0, rep=0 (a start then reaches END, done after 2 cycles).
- Table {0:(3,1),1:(4,1)}, start_last=1, loop=1 -> count 0(SEEK),0,1,2,3,0(SEEK),0,1,2,3,4,0(SEEK),0..3,…; tick at counts 3 and 4; phase_done on the same cycles; busy stays 1.
- Same table, loop=0 -> the sequence above runs once, then END with done=1 for one cycle; busy drops in the END cycle; then IDLE.
- Table {0:(1,3),1:(2,0),2:(2,1)}, last=2, loop=0 -> phase 0 runs 0,1 three times (tick ×3, phase_done on the 3rd); two SEEK cycles (skip phase 1); phase 2 runs 0,1,2; then done.
- All rep=0, last=3, loop=1 -> 4 SEEK cycles, then END/done (no infinite loop).
- stop asserted at phase 1, count 2 -> next cycle IDLE, count=0, phase=0, done never pulses. cfg_we during RUN -> cfg_err pulse and the table is unchanged. start during RUN -> ignored.

Source files
------------

// File: rtl/mod_seq_ctrl.sv
// mod_seq_ctrl: programmable modulus-sequence scheduler stepping one counter through a phase table
module mod_seq_ctrl #(
    parameter int CW  = 4,
    parameter int NPH = 4,
    parameter int PW  = 2,
    parameter int RW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_addr,
    input  logic [CW-1:0] cfg_mod,
    input  logic [RW-1:0] cfg_rep,
    input  logic          start,
    input  logic [PW-1:0] start_last,
    input  logic          start_loop,
    input  logic          stop,
    output logic [CW-1:0] count,
    output logic [PW-1:0] phase,
    output logic          tick,
    output logic          phase_done,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);
    typedef enum logic [1:0] {IDLE, SEEK, RUN, END} state_t;
    state_t        state, state_n;
    logic [CW-1:0] mods [NPH];
    logic [RW-1:0] reps [NPH];
    logic [CW-1:0] count_n;
    logic [PW-1:0] phase_n, last;
    logic [RW-1:0] pass, pass_n;
    logic          loop, any_rep, go;

    always_comb begin
        any_rep = 1'b0;
        for (int i = 0; i < NPH; i++) any_rep = any_rep | (i <= int'(last) && reps[i] != '0);
        tick       = state == RUN && count == mods[phase];
        phase_done = tick && pass == reps[phase] - RW'(1);
        busy       = state == SEEK || state == RUN;
        done       = state == END;
        go         = state == IDLE && start && !stop;
        state_n    = state;
        count_n    = count;
        phase_n    = phase;
        pass_n     = pass;
        if ((busy && stop) || state == END) begin
            state_n = IDLE;
            count_n = '0;
            phase_n = '0;
            pass_n  = '0;
        end else if (go) begin
            state_n = SEEK;
            phase_n = '0;
            pass_n  = '0;
        end else if (state == SEEK) begin
            // empty entries are skipped one cycle each; an all-empty looped table ends instead of spinning
            if (reps[phase] != '0) begin
                state_n = RUN;
                pass_n  = '0;
            end else if (phase < last) begin
                phase_n = phase + 1'b1;
            end else begin
                state_n = loop && any_rep ? SEEK : END;
                phase_n = '0;
            end
        end else if (state == RUN) begin
            count_n = tick ? '0 : count + 1'b1;
            pass_n  = tick ? pass + 1'b1 : pass;
            if (phase_done) begin
                pass_n  = '0;
                state_n = phase < last || loop ? SEEK : END;
                phase_n = phase < last ? phase + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            phase   <= '0;
            pass    <= '0;
            last    <= '0;
            loop    <= 1'b0;
            cfg_err <= 1'b0;
            for (int i = 0; i < NPH; i++) begin
                mods[i] <= '0;
                reps[i] <= '0;
            end
        end else begin
            state   <= state_n;
            count   <= count_n;
            phase   <= phase_n;
            pass    <= pass_n;
            cfg_err <= cfg_we && busy;
            if (cfg_we && !busy) begin
                mods[cfg_addr] <= cfg_mod;
                reps[cfg_addr] <= cfg_rep;
            end
            if (go) begin
                last <= start_last;
                loop <= start_loop;
            end
        end
    end
endmodule

// File: tb/tb_mod_seq_ctrl.sv
// tb_mod_seq_ctrl: directed bench comparing mod_seq_ctrl against a trace-building phase-table model
module tb_mod_seq_ctrl;
    logic       clk = 1'b0, rst = 1'b0, cfg_we = 1'b0, start = 1'b0, start_loop = 1'b0, stop = 1'b0;
    logic [1:0] cfg_addr = '0, start_last = '0, phase;
    logic [3:0] cfg_mod = '0, cfg_rep = '0, count;
    logic       tick, phase_done, busy, done, cfg_err;

    typedef struct packed {
        logic [3:0] c;
        logic [1:0] p;
        logic       t, pd, b, d, e;
    } obs_t;

    obs_t       q[$];
    int         tbl_mod [4];
    int         tbl_rep [4];
    logic       exp_err = 1'b0;
    int         n_cmp = 0, n_fail = 0;
    int         t4_cnt [13] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 2, 0};

    mod_seq_ctrl dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mod(cfg_mod),
        .cfg_rep(cfg_rep), .start(start), .start_last(start_last), .start_loop(start_loop),
        .stop(stop), .count(count), .phase(phase), .tick(tick), .phase_done(phase_done),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic obs_t mk(int c, int p, bit t, bit pd, bit b, bit d);
        obs_t o;
        o.c  = 4'(c);
        o.p  = 2'(p);
        o.t  = t;
        o.pd = pd;
        o.b  = b;
        o.d  = d;
        o.e  = 1'b0;
        return o;
    endfunction

    // Expected per-cycle trace from the cycle after the start edge: a SEEK bubble before each
    // visited entry, then rep passes of 0..mod, then END when the sequence does not wrap.
    function automatic void build(int last, bit lp, int limit);
        int p = 0;
        bit any = 0;
        for (int i = 0; i <= last; i++) any |= tbl_rep[i] != 0;
        q.delete();
        while (q.size() < limit) begin
            q.push_back(mk(0, p, 0, 0, 1, 0));
            for (int r = 0; r < tbl_rep[p]; r++)
                for (int c = 0; c <= tbl_mod[p]; c++)
                    q.push_back(mk(c, p, c == tbl_mod[p], c == tbl_mod[p] && r == tbl_rep[p] - 1, 1, 0));
            if (p < last) p++;
            else if (lp && any) p = 0;
            else begin
                q.push_back(mk(0, 0, 0, 0, 0, 1));
                break;
            end
        end
    endfunction

    always @(negedge clk) begin
        obs_t e, a;
        e   = q.size() > 0 ? q.pop_front() : mk(0, 0, 0, 0, 0, 0);
        e.e = exp_err;
        a   = {count, phase, tick, phase_done, busy, done, cfg_err};
        chk("cycle", 32'(a), 32'(e));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int a, input int m, input int r);
        cfg_addr = 2'(a);
        cfg_mod  = 4'(m);
        cfg_rep  = 4'(r);
        cfg_we   = 1'b1;
        step();
        cfg_we     = 1'b0;
        tbl_mod[a] = m;
        tbl_rep[a] = r;
    endtask

    task automatic start_seq(input int last, input bit lp);
        start_last = 2'(last);
        start_loop = lp;
        start      = 1'b1;
        step();
        start = 1'b0;
        build(last, lp, 64);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tbl_mod[i] = 0;
            tbl_rep[i] = 0;
        end
        repeat (2) step();
        rst = 1'b1;
        step();
        // two-phase loop, interrupted by a rejected write, an ignored start and a stop
        wr(0, 3, 1);
        wr(1, 4, 1);
        start_seq(1, 1);
        chk("model_t2_idx8", {q[8].c, q[8].p}, {4'd2, 2'd1});
        chk("model_t2_idx4_tick", {q[4].t, q[4].pd}, 2'b11);
        chk("model_t2_idx10", {q[10].c, q[10].t, q[10].pd}, {4'd4, 2'b11});
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                cfg_addr = 2'd0;
                cfg_mod  = 4'd7;
                cfg_rep  = 4'd2;
                cfg_we   = 1'b1;
            end
            if (i == 4) begin
                cfg_we  = 1'b0;
                exp_err = 1'b1;
            end
            if (i == 5) exp_err = 1'b0;
            if (i == 6) start = 1'b1;
            if (i == 7) start = 1'b0;
            if (i == 19) stop = 1'b1;
            step();
        end
        q.delete();
        stop = 1'b0;
        step();
        // same table run once
        start_seq(1, 0);
        chk("model_t3_len", q.size(), 12);
        repeat (q.size() + 2) step();
        // skipped middle entry
        wr(0, 1, 3);
        wr(1, 2, 0);
        wr(2, 2, 1);
        start_seq(2, 0);
        chk("model_t4_len", q.size(), 13);
        for (int i = 0; i < 13; i++) chk("model_t4_cnt", q[i].c, t4_cnt[i]);
        chk("model_t4_flags", {q[6].pd, q[7].b, q[8].p, q[11].pd, q[12].d}, {1'b1, 1'b1, 2'd2, 1'b1, 1'b1});
        repeat (q.size() + 2) step();
        // all entries empty with loop
        for (int i = 0; i < 4; i++) wr(i, 2, 0);
        start_seq(3, 1);
        chk("model_t5_len", q.size(), 5);
        repeat (q.size() + 2) step();
        // start/stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) step();
        // asynchronous reset mid-run
        wr(0, 3, 1);
        wr(1, 4, 1);
        start_seq(1, 1);
        repeat (3) step();
        chk("pre_reset_count", count, 4'd2);
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            tbl_mod[i] = 0;
            tbl_rep[i] = 0;
        end
        #1;
        chk("async_reset_outs", {count, phase, tick, phase_done, busy, done, cfg_err}, '0);
        step();
        rst = 1'b1;
        step();
        start_seq(0, 0);
        chk("model_rst_len", q.size(), 2);
        chk("model_rst_done", q[1].d, 1'b1);
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
